// File: rtl/rr_grant_capture_if.sv
// Grant/data capture bus between the arbiter side, the requesters and the shared sink.
// The stat_cnt signal exists only when RRC_GRANT_STATS_EN is defined.
interface rr_grant_capture_if #(
    parameter int unsigned DW = 8
`ifdef RRC_GRANT_STATS_EN
    , parameter int unsigned CNT_W = 16
`endif
);
    logic [3:0]      grant;
    logic [4*DW-1:0] req_data;
    logic [3:0]      ack;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;
    logic            grant_err;
`ifdef RRC_GRANT_STATS_EN
    logic [4*CNT_W-1:0] stat_cnt;
`endif

    modport master (
        output grant, req_data, out_ready,
        input  ack, out_valid, out_data, out_id, grant_err
`ifdef RRC_GRANT_STATS_EN
        , input stat_cnt
`endif
    );

    modport slave (
        input  grant, req_data, out_ready,
        output ack, out_valid, out_data, out_id, grant_err
`ifdef RRC_GRANT_STATS_EN
        , output stat_cnt
`endif
    );
endinterface

// File: rtl/rr_grant_capture.sv
// Captures the granted requester word and its ID into a small FIFO drained over valid/ready.
// Optional per-requester saturating grant counters are enabled by defining RRC_GRANT_STATS_EN.
module rr_grant_capture #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
`ifdef RRC_GRANT_STATS_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input logic           clk,
    input logic           rst,
    rr_grant_capture_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [DW-1:0] mem_data [DEPTH];
    logic [1:0]    mem_id   [DEPTH];
    logic          err_q;

    logic          onehot;
    logic          multihot;
    logic [1:0]    enc;
    logic [DW-1:0] wr_data;
    logic          push;
    logic          pop;
    logic          head_valid;

`ifdef RRC_GRANT_STATS_EN
    logic [CNT_W-1:0] stat_q [4];
`endif

    // Grant decode, push/pop arbitration and output presentation
    always_comb begin
        onehot     = (bus.grant != 4'd0) && ((bus.grant & (bus.grant - 4'd1)) == 4'd0);
        multihot   = (bus.grant != 4'd0) && !onehot;
        enc        = 2'd0;
        case (bus.grant)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
        wr_data    = bus.req_data[DW*int'(enc) +: DW];
        head_valid = (count != '0);
        pop        = head_valid && bus.out_ready && !rst;
        // A full FIFO still accepts when the head leaves in the same cycle
        push       = onehot && !rst && ((count < CW'(DEPTH)) || pop);
        count_nxt  = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        bus.ack       = bus.grant & {4{push}};
        bus.out_valid = head_valid;
        bus.out_data  = mem_data[rd_ptr];
        bus.out_id    = mem_id[rd_ptr];
        bus.grant_err = err_q;
`ifdef RRC_GRANT_STATS_EN
        bus.stat_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            bus.stat_cnt[i*CNT_W +: CNT_W] = stat_q[i];
        end
`endif
    end

    // FIFO storage, pointers, sticky error and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data[i] <= '0;
                mem_id[i]   <= '0;
            end
`ifdef RRC_GRANT_STATS_EN
            for (int i = 0; i < 4; i++) begin
                stat_q[i] <= '0;
            end
`endif
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= wr_data;
                mem_id[wr_ptr]   <= enc;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            if (multihot) begin
                err_q <= 1'b1;
            end
`ifdef RRC_GRANT_STATS_EN
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i] && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + CNT_W'(1);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_rr_grant_capture.sv
// Scoreboard bench for rr_grant_capture; define RRC_GRANT_STATS_EN to also cover the grant counters.
module tb_rr_grant_capture;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int passed = 0;
    logic [9:0] sb [$];

`ifdef RRC_GRANT_STATS_EN
    rr_grant_capture_if #(.DW(DW), .CNT_W(4)) bus ();
    rr_grant_capture #(.DW(DW), .DEPTH(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    rr_grant_capture_if #(.DW(DW)) bus ();
    rr_grant_capture #(.DW(DW), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Pops the scoreboard whenever the sink takes the head
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_underflow got id=%0d data=%h with empty scoreboard", bus.out_id, bus.out_data);
            end else begin
                logic [9:0] exp;
                exp = sb.pop_front();
                if ({bus.out_id, bus.out_data} !== exp)
                    $display("FAIL sb_head got id=%0d data=%h exp id=%0d data=%h",
                             bus.out_id, bus.out_data, exp[9:8], exp[7:0]);
                else passed++;
            end
        end
    end

    task automatic drive(input logic [3:0] g, input logic [4*DW-1:0] d, input logic rdy);
        @(posedge clk);
        #1;
        bus.grant     = g;
        bus.req_data  = d;
        bus.out_ready = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sb.delete();
        for (int c = 0; c < 2; c++) begin
            drive(4'b0001, 32'h0000_00FF, 1'b1);
            @(negedge clk);
            checks++;
            if (bus.ack !== 4'b0000) $display("FAIL reset_ack got %b exp 0000", bus.ack);
            else passed++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.grant = 4'b0000;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_id, bus.grant_err} !== 12'h000)
            $display("FAIL reset_state got v=%b d=%h id=%0d err=%b exp all zero",
                     bus.out_valid, bus.out_data, bus.out_id, bus.grant_err);
        else passed++;
    endtask

    task automatic test_single_capture();
        drive(4'b0001, 32'h0000_00A5, 1'b1);
        sb.push_back({2'd0, 8'hA5});
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0001) $display("FAIL single_ack got %b exp 0001", bus.ack);
        else passed++;
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL single_no_bypass got %b exp 0", bus.out_valid);
        else passed++;
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_id, bus.out_data} !== {1'b1, 2'd0, 8'hA5})
            $display("FAIL single_head got v=%b id=%0d d=%h exp v=1 id=0 d=a5",
                     bus.out_valid, bus.out_id, bus.out_data);
        else passed++;
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL single_empty got %b exp 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_fill_backpressure();
        logic [3:0] g;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            g = 4'(1 << i);
            d = 8'(8'h11 * (i + 1));
            drive(g, {4{d}}, 1'b0);
            sb.push_back({2'(i), d});
            @(negedge clk);
            checks++;
            if (bus.ack !== g) $display("FAIL fill_ack%0d got %b exp %b", i, bus.ack, g);
            else passed++;
        end
        drive(4'b0001, 32'h0000_0055, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0000) $display("FAIL full_ack got %b exp 0000", bus.ack);
        else passed++;
        drive(4'b0001, 32'h0000_0055, 1'b1);
        sb.push_back({2'd0, 8'h55});
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0001) $display("FAIL full_pop_push_ack got %b exp 0001", bus.ack);
        else passed++;
        drive(4'b0000, 32'h0, 1'b1);
        for (int c = 0; c < 12 && bus.out_valid !== 1'b0; c++) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || sb.size() != 0)
            $display("FAIL fill_drain got v=%b left=%0d exp v=0 left=0", bus.out_valid, sb.size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] g;
        logic [7:0] d;
        for (int k = 0; k < 10; k++) begin
            g = 4'(1 << (k % 4));
            d = 8'($urandom_range(0, 255));
            drive(g, {4{d}}, 1'b1);
            sb.push_back({2'(k % 4), d});
            @(negedge clk);
            checks++;
            if (bus.ack !== g) $display("FAIL wrap_ack%0d got %b exp %b", k, bus.ack, g);
            else passed++;
        end
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || sb.size() != 0)
            $display("FAIL wrap_depth got v=%b left=%0d exp v=0 left=0", bus.out_valid, sb.size());
        else passed++;
    endtask

    task automatic test_grant_err();
        drive(4'b0110, 32'h3333_3333, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.ack, bus.grant_err} !== 5'b0000_0) $display("FAIL err_ack got ack=%b err=%b exp 0000/0", bus.ack, bus.grant_err);
        else passed++;
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.grant_err, bus.out_valid} !== 2'b10)
            $display("FAIL err_set got err=%b v=%b exp err=1 v=0", bus.grant_err, bus.out_valid);
        else passed++;
        for (int c = 0; c < 3; c++) drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.grant_err !== 1'b1) $display("FAIL err_sticky got %b exp 1", bus.grant_err);
        else passed++;
    endtask

    task automatic test_mid_reset();
        drive(4'b0100, 32'h00AA_0000, 1'b0);
        drive(4'b1000, 32'hBB00_0000, 1'b0);
        test_reset();
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL midreset_flush got %b exp 0", bus.out_valid);
        else passed++;
    endtask

`ifdef RRC_GRANT_STATS_EN
    task automatic test_stats();
        logic [15:0] s;
        for (int k = 0; k < 20; k++) begin
            drive(4'b0100, 32'h0077_0000, 1'b1);
            sb.push_back({2'd2, 8'h77});
        end
        drive(4'b0000, 32'h0, 1'b1);
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        s = bus.stat_cnt;
        checks++;
        if (s !== 16'h0F00) $display("FAIL stats_sat got %h exp 0f00", s);
        else passed++;
    endtask
`endif

    initial begin
        bus.grant     = 4'b0000;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_capture();
        test_fill_backpressure();
        test_back_to_back();
        test_grant_err();
        test_mid_reset();
`ifdef RRC_GRANT_STATS_EN
        test_stats();
`endif
        drive(4'b0000, 32'h0, 1'b0);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
